// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu #(N) between two requesters with round-robin
// arbitration. A winning command is registered onto the alu_* outputs. The ALU
// result and flags are captured one cycle later. They are then held on a shared
// response channel, tagged with the requester id, until the consumer takes them.
//
// Optional build macro: ALU_ARB_STATS_EN
//   When defined, the block adds the grant_cnt0/grant_cnt1 outputs. These are
//   16-bit saturating counts of commands accepted per port.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   reqX_valid/reqX_ready            command handshake for requester X (0/1)
//   reqX_opcode/a/b/cin              command operands for requester X
//   resp_valid/resp_ready            response handshake
//   resp_id                          requester that issued the command
//   resp_y, resp_cout, resp_overflow,
//   resp_negative, resp_zero         captured ALU result and flags
//   alu_opcode/a/b/cin               registered operands driven to the alu
//   alu_y, alu_cout, alu_overflow,
//   alu_negative, alu_zero           combinational alu result and flags
//   grant_cnt0/1                     per-port accept counters (stats build only)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N   = 4,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_opcode,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic [N-1:0]   req0_cin,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_opcode,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  input  logic [N-1:0]   req1_cin,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [N-1:0]   resp_y,
  output logic           resp_cout,
  output logic           resp_overflow,
  output logic           resp_negative,
  output logic           resp_zero,
  output logic [OPW-1:0] alu_opcode,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [N-1:0]   alu_cin,
  input  logic [N-1:0]   alu_y,
  input  logic           alu_cout,
  input  logic           alu_overflow,
  input  logic           alu_negative,
  input  logic           alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [OPW-1:0] op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, cin_q, cin_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_id_q, resp_id_d;
  logic [N-1:0]   resp_y_q, resp_y_d;
  logic           cout_q, cout_d, ovf_q, ovf_d, neg_q, neg_d, zero_q, zero_d;
  logic           grant;
  logic           accept;

  // Round-robin grant and ready generation; a tie goes to the port not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    req0_ready = (state_q == IDLE) && !grant && req0_valid && !reset;
    req1_ready = (state_q == IDLE) &&  grant && req1_valid && !reset;
    accept     = req0_ready || req1_ready;
  end

  // Next-state logic for the FSM, operand registers and response registers.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    neg_d        = neg_q;
    zero_d       = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = grant;
          op_d         = grant ? req1_opcode : req0_opcode;
          a_d          = grant ? req1_a      : req0_a;
          b_d          = grant ? req1_b      : req0_b;
          cin_d        = grant ? req1_cin    : req0_cin;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // The alu has seen the registered operands for a full cycle.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_id_d    = last_grant_q;
        resp_y_d     = alu_y;
        cout_d       = alu_cout;
        ovf_d        = alu_overflow;
        neg_d        = alu_negative;
        zero_d       = alu_zero;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State, operand and response registers. Reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
      neg_q        <= neg_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_opcode    = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_cin       = cin_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_y        = resp_y_q;
  assign resp_cout     = cout_q;
  assign resp_overflow = ovf_q;
  assign resp_negative = neg_q;
  assign resp_zero     = zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-port accept counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != 16'hFFFF)) begin
      cnt0_d = cnt0_q + 16'd1;
    end else begin
      cnt0_d = cnt0_q;
    end
    if (req1_ready && (cnt1_q != 16'hFFFF)) begin
      cnt1_d = cnt1_q + 16'd1;
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
